// File: rtl/mc_dp_pkg.sv
// Shared types for the multi-cycle datapath: ALU opcodes, mux select codes,
// memory handshake FSM states and register file geometry.
package mc_dp_pkg;

    localparam int RF_DEPTH = 16;
    localparam int RF_IDX_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_NOTB  = 3'd5,
        ALU_PASSB = 3'd6,
        ALU_SLT   = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B     = 2'b00,
        SRCB_STEP  = 2'b01,
        SRCB_IMM12 = 2'b10,
        SRCB_IMM26 = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        RD_ALUOUT = 2'b00,
        RD_MDR    = 2'b01,
        RD_PC     = 2'b10,
        RD_RSVD   = 2'b11
    } reg_data_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mc_regfile_p.sv
// 16-entry register file: two combinational read ports, one write port on
// the rising edge. A read of the register being written returns the old value.
module mc_regfile_p
    import mc_dp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [RF_IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic [RF_IDX_W-1:0] i_raddr1,
    input  logic [RF_IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]     o_rdata1,
    output logic [XLEN-1:0]     o_rdata2
);

    logic [XLEN-1:0] r_mem [0:RF_DEPTH-1];

    // Synchronous write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/mc_datapath_hs.sv
// Multi-cycle datapath with PC/IR/MDR/A/B/ALUOUT, register file, ALU, flags
// and a two-state valid/ready memory port that tolerates any wait states.
module mc_datapath_hs
    import mc_dp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = {{(XLEN-1){1'b0}}, 1'b1},
    parameter int              LINK_REG = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic            lord,
    input  logic            ir_write,
    input  logic            data_to_mem,
    input  logic            reg_write,
    input  logic            link,
    input  logic [1:0]      reg_data,
    input  logic            alusrca,
    input  logic [1:0]      alusrcb,
    input  alu_op_e         alu_op,
    input  logic            pc_write,
    input  logic            pcsrc,
    input  logic            ldz,
    input  logic            ldc,
    input  logic            ldn,
    input  logic            ldv,
    output logic            mem_valid,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            mem_done,
    output logic            busy,
    output logic            proto_err,
    output logic [31:0]     inst,
    output logic            z,
    output logic            c,
    output logic            n,
    output logic            v
);

    localparam int              MSB     = XLEN - 1;
    localparam logic [RF_IDX_W-1:0] LP_LINK = RF_IDX_W'(LINK_REG);

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] x);
        return {{(XLEN-12){x[11]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] sext26(input logic [25:0] x);
        return {{(XLEN-26){x[25]}}, x};
    endfunction

    logic [XLEN-1:0]     r_pc, r_mdr, r_a, r_b, r_aluout, r_addr, r_wdata;
    logic [31:0]         r_ir;
    logic                r_z, r_c, r_n, r_v, r_wr, r_irw, r_done, r_perr;
    mem_state_e          r_state, w_state_nxt;
    logic                w_valid;
    logic [XLEN-1:0]     w_rd1, w_rd2, w_src_a, w_src_b, w_res, w_wb_data;
    logic [XLEN:0]       w_sum, w_dif;
    logic                w_c, w_v;
    logic [RF_IDX_W-1:0] w_rs2, w_wb_idx;

    assign w_rs2    = data_to_mem ? r_ir[15:12] : r_ir[3:0];
    assign w_wb_idx = link ? LP_LINK : r_ir[15:12];
    assign w_src_a  = alusrca ? r_a : r_pc;

    mc_regfile_p #(.XLEN(XLEN)) u_rf (
        .clk      (clk),
        .i_we     (reg_write),
        .i_waddr  (w_wb_idx),
        .i_wdata  (w_wb_data),
        .i_raddr1 (r_ir[19:16]),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Operand B and write-back data selection.
    always_comb begin
        w_src_b   = r_b;
        w_wb_data = '0;
        case (alusrcb_e'(alusrcb))
            SRCB_B:     w_src_b = r_b;
            SRCB_STEP:  w_src_b = PC_STEP;
            SRCB_IMM12: w_src_b = sext12(r_ir[11:0]);
            SRCB_IMM26: w_src_b = sext26(r_ir[25:0]);
            default:    w_src_b = r_b;
        endcase
        case (reg_data_e'(reg_data))
            RD_ALUOUT: w_wb_data = r_aluout;
            RD_MDR:    w_wb_data = r_mdr;
            RD_PC:     w_wb_data = r_pc;
            default:   w_wb_data = '0;
        endcase
    end

    // ALU result with carry (not-borrow for SUB) and signed overflow.
    always_comb begin
        w_sum = {1'b0, w_src_a} + {1'b0, w_src_b};
        w_dif = {1'b0, w_src_a} + {1'b0, ~w_src_b} + {{XLEN{1'b0}}, 1'b1};
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[XLEN];
                w_v   = (w_src_a[MSB] == w_src_b[MSB]) && (w_sum[MSB] != w_src_a[MSB]);
            end
            ALU_SUB: begin
                w_res = w_dif[MSB:0];
                w_c   = w_dif[XLEN];
                w_v   = (w_src_a[MSB] != w_src_b[MSB]) && (w_dif[MSB] != w_src_a[MSB]);
            end
            ALU_AND:   w_res = w_src_a & w_src_b;
            ALU_OR:    w_res = w_src_a | w_src_b;
            ALU_XOR:   w_res = w_src_a ^ w_src_b;
            ALU_NOTB:  w_res = ~w_src_b;
            ALU_PASSB: w_res = w_src_b;
            ALU_SLT:   w_res = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            default:   w_res = '0;
        endcase
    end

    // Operand/result registers load every cycle; PC and flags only on enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_res;
            if (pc_write) r_pc <= pcsrc ? r_aluout : w_res;
            if (ldz)      r_z  <= (w_res == '0);
            if (ldc)      r_c  <= w_c;
            if (ldn)      r_n  <= w_res[MSB];
            if (ldv)      r_v  <= w_v;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: accept a request in IDLE, finish on ready in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: if (mem_req) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                w_valid = 1'b1;
                if (mem_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch access attributes on acceptance; capture read data on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_irw   <= 1'b0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_mdr   <= '0;
            r_ir    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE && mem_req) begin
                r_addr  <= lord ? r_aluout : r_pc;
                r_wdata <= r_b;
                r_wr    <= mem_we;
                r_irw   <= ir_write;
            end
            if (r_state == ST_WAIT) begin
                if (mem_req) r_perr <= 1'b1;
                if (mem_ready) begin
                    r_done <= 1'b1;
                    if (!r_wr) begin
                        r_mdr <= mem_rdata;
                        if (r_irw) r_ir <= mem_rdata[31:0];
                    end
                end
            end
        end
    end

    assign mem_valid = w_valid;
    assign busy      = w_valid;
    assign mem_wr    = r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_done  = r_done;
    assign proto_err = r_perr;
    assign inst      = r_ir;
    assign z         = r_z;
    assign c         = r_c;
    assign n         = r_n;
    assign v         = r_v;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: ALU/flag vector table plus hand-written
// handshake, link and reset-abort sequences.
module tb_mc_datapath_hs;
    import mc_dp_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] IRW = 32'h000F_0040;

    logic        clk = 1'b0;
    logic        rst, mem_req, mem_we, lord, ir_write, data_to_mem;
    logic        reg_write, link, alusrca, pc_write, pcsrc;
    logic        ldz, ldc, ldn, ldv, mem_ready;
    logic [1:0]  reg_data, alusrcb;
    alu_op_e     alu_op;
    logic [31:0] mem_rdata;
    logic        mem_valid, mem_wr, mem_done, busy, proto_err, z, c, n, v;
    logic [31:0] mem_addr, mem_wdata, inst;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ez, ec, en, ev;
    } vec_t;
    vec_t vecs[12];

    mc_datapath_hs #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .lord(lord),
        .ir_write(ir_write), .data_to_mem(data_to_mem), .reg_write(reg_write),
        .link(link), .reg_data(reg_data), .alusrca(alusrca), .alusrcb(alusrcb),
        .alu_op(alu_op), .pc_write(pc_write), .pcsrc(pcsrc), .ldz(ldz), .ldc(ldc),
        .ldn(ldn), .ldv(ldv), .mem_valid(mem_valid), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_done(mem_done), .busy(busy),
        .proto_err(proto_err), .inst(inst), .z(z), .c(c), .n(n), .v(v)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One complete memory access with a given number of wait states.
    task automatic access(input logic we, input logic lrd, input logic irw,
                          input logic [31:0] rdata, input int waits,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        mem_req = 1'b1; mem_we = we; lord = lrd; ir_write = irw; mem_ready = 1'b0;
        step();
        mem_req = 1'b0; mem_we = 1'b0; lord = 1'b0; ir_write = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            chk("valid_hi", mem_valid, 1'b1);
            chk("addr", mem_addr, exp_addr);
            chk("wr", mem_wr, we);
            if (we) chk("wdata", mem_wdata, exp_wdata);
            chk("done_early", mem_done, 1'b0);
            if (k == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        chk("done", mem_done, 1'b1);
        chk("valid_lo", mem_valid, 1'b0);
        step();
        chk("done_pulse", mem_done, 1'b0);
    endtask

    task automatic wr_rf(input logic lnk, input logic [1:0] sel);
        reg_write = 1'b1; link = lnk; reg_data = sel;
        step();
        reg_write = 1'b0; link = 1'b0; reg_data = 2'b00;
    endtask

    initial begin
        vecs[0]  = '{ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{ALU_SUB,   32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{ALU_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{ALU_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_XOR,   32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{ALU_NOTB,  32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{ALU_PASSB, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{ALU_SLT,   32'h00000005, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; lord = 1'b0; ir_write = 1'b0;
        data_to_mem = 1'b0; reg_write = 1'b0; link = 1'b0; reg_data = 2'b00;
        alusrca = 1'b0; alusrcb = 2'b00; alu_op = ALU_ADD; pc_write = 1'b0;
        pcsrc = 1'b0; ldz = 1'b0; ldc = 1'b0; ldn = 1'b0; ldv = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        step();
        rst = 1'b0;
        chk("rst_valid", mem_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", mem_done, 1'b0);
        chk("rst_perr", proto_err, 1'b0);
        chk("rst_flags", {28'h0, z, c, n, v}, 32'h0);
        chk("rst_inst", inst, 32'h0);

        // Stray ready while idle must not produce a completion.
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_ready = 1'b0;
        chk("idle_ready_done", mem_done, 1'b0);
        chk("idle_ready_inst", inst, 32'h0);

        // Fetch with three wait states; address is the reset PC.
        access(1'b0, 1'b0, 1'b1, 32'hE2811005, 3, RPC, 32'h0);
        chk("fetch_inst", inst, 32'hE2811005);

        // Working instruction word: rs1=R15, rd=R0, rs2=R0, imm12=0x040.
        access(1'b0, 1'b0, 1'b1, IRW, 0, RPC, 32'h0);
        chk("fetch2_inst", inst, IRW);

        // Store, zero wait states: B=DEADBEEF, ALUOUT=0x40.
        access(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 0, RPC, 32'h0);
        wr_rf(1'b0, 2'b01);
        alusrca = 1'b0; alusrcb = 2'b10; alu_op = ALU_PASSB;
        step();
        access(1'b1, 1'b1, 1'b0, 32'h11111111, 0, 32'h40, 32'hDEADBEEF);
        chk("store_inst", inst, IRW);
        wr_rf(1'b0, 2'b01);
        step();
        access(1'b1, 1'b1, 1'b0, 32'h22222222, 1, 32'h40, 32'hDEADBEEF);

        // ALU / flag table: A=R15 (via link), B=R0.
        for (int i = 0; i < 12; i++) begin
            access(1'b0, 1'b0, 1'b0, vecs[i].a, 0, RPC, 32'h0);
            wr_rf(1'b1, 2'b01);
            access(1'b0, 1'b0, 1'b0, vecs[i].b, 0, RPC, 32'h0);
            wr_rf(1'b0, 2'b01);
            alusrca = 1'b1; alusrcb = 2'b00; alu_op = vecs[i].op;
            step();
            ldz = 1'b1; ldc = 1'b1; ldn = 1'b1; ldv = 1'b1;
            step();
            ldz = 1'b0; ldc = 1'b0; ldn = 1'b0; ldv = 1'b0;
            chk($sformatf("v%0d_z", i), z, vecs[i].ez);
            chk($sformatf("v%0d_c", i), c, vecs[i].ec);
            chk($sformatf("v%0d_n", i), n, vecs[i].en);
            chk($sformatf("v%0d_v", i), v, vecs[i].ev);
            access(1'b0, 1'b1, 1'b0, 32'h0, i % 2, vecs[i].res, 32'h0);
        end

        // Request during WAIT: flagged, ignored, transaction still completes.
        mem_req = 1'b1; mem_we = 1'b0; lord = 1'b0; ir_write = 1'b0;
        step();
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        chk("perr_set", proto_err, 1'b1);
        chk("perr_valid", mem_valid, 1'b1);
        chk("perr_busy", busy, 1'b1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        step();
        mem_ready = 1'b0;
        chk("perr_done", mem_done, 1'b1);
        chk("perr_valid_lo", mem_valid, 1'b0);
        chk("perr_busy_lo", busy, 1'b0);
        // Back-to-back request in the done cycle.
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        chk("b2b_valid", mem_valid, 1'b1);
        chk("b2b_done_lo", mem_done, 1'b0);
        chk("b2b_addr", mem_addr, RPC);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("b2b_done", mem_done, 1'b1);
        step();
        chk("perr_sticky", proto_err, 1'b1);
        chk("b2b_inst", inst, IRW);

        // Link write of PC, PC increment, and PC write from the ALU.
        alusrca = 1'b1; alusrcb = 2'b01; alu_op = ALU_ADD;
        wr_rf(1'b1, 2'b10);
        step();
        step();
        access(1'b0, 1'b1, 1'b0, 32'h0, 0, RPC + 32'd1, 32'h0);
        pc_write = 1'b1; pcsrc = 1'b0;
        step();
        pc_write = 1'b0;
        access(1'b0, 1'b0, 1'b0, 32'h0, 0, RPC + 32'd1, 32'h0);
        // Reserved write-back select stores zero.
        wr_rf(1'b0, 2'b11);
        step();
        access(1'b1, 1'b1, 1'b0, 32'h0, 0, RPC + 32'd1, 32'h0);

        // Reset in the middle of a pending fetch.
        mem_req = 1'b1; ir_write = 1'b1;
        step();
        mem_req = 1'b0; ir_write = 1'b0;
        chk("abort_valid_pre", mem_valid, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", mem_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_perr", proto_err, 1'b0);
        chk("abort_z", z, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        chk("abort_done", mem_done, 1'b0);
        chk("abort_inst", inst, 32'h0);
        step();
        chk("abort_done2", mem_done, 1'b0);
        access(1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 0, RPC, 32'h0);
        chk("post_abort_inst", inst, 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
